// File: rtl/param_cfg_arb.sv
// -----------------------------------------------------------------------------
// param_cfg_arb
//
// Round-robin arbiter in front of a two-slot parameter store (A and B).
// One requester at a time wins a write of its value into the selected slot.
// The first write to a slot defines it. A later write of the same value counts
// as a compatible redefinition (dup_cnt, saturating). A later write of a
// different value is rejected and sets the sticky err flag.
//
// Each transaction walks IDLE -> GRANT -> COMMIT -> IDLE, so a new
// transaction can start at most every 3 cycles. gnt is high only in GRANT,
// and done is high only in COMMIT. Slot outputs are already updated in the
// COMMIT cycle.
//
// Optional feature, compiled in with `define PARAM_CFG_ARB_LOCK_EN:
//   adds a lock input and a locked output. Once locked, commits are discarded
//   and flagged on err. Only clr or reset releases the lock.
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   DW        parameter value width
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       per-requester write request, held until own gnt bit seen
//   req_sel   per-requester slot select (0 = A, 1 = B)
//   req_data  per-requester value, requester i at [i*DW +: DW]
//   clr       synchronous clear of slot values, valid, dup_cnt, err (and locked)
//   lock      (PARAM_CFG_ARB_LOCK_EN) sets the sticky lock
//   locked    (PARAM_CFG_ARB_LOCK_EN) lock state
//   gnt       one-hot registered grant, high during GRANT only
//   done      one-cycle pulse in COMMIT
//   param_a   slot A value
//   param_b   slot B value
//   valid     slot defined flags, bit0 = A, bit1 = B
//   dup_cnt   compatible redefinition count, saturates at 255
//   err       sticky incompatible-redefinition (or locked-commit) flag
//   busy      high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module param_cfg_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_sel,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 clr,
`ifdef PARAM_CFG_ARB_LOCK_EN
    input  logic                 lock,
    output logic                 locked,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic                 done,
    output logic [DW-1:0]        param_a,
    output logic [DW-1:0]        param_b,
    output logic [1:0]           valid,
    output logic [7:0]           dup_cnt,
    output logic                 err,
    output logic                 busy
);

    localparam int unsigned   IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [IW-1:0]   win_q,   win_d;
    logic            sel_q,   sel_d;
    logic [DW-1:0]   data_q,  data_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic            done_q,  done_d;
    logic [DW-1:0]   pa_q,    pa_d;
    logic [DW-1:0]   pb_q,    pb_d;
    logic [1:0]      vld_q,   vld_d;
    logic [7:0]      dup_q,   dup_d;
    logic            err_q,   err_d;

    logic            commit;
    logic            lock_hit;

    logic            win_found;
    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic            win_sel;
    logic [DW-1:0]   win_data;

    logic            slot_vld;
    logic [DW-1:0]   slot_val;

    // -------------------------------------------------------------------------
    // Round-robin pick. Two passes avoid modulo index math: the first pass
    // looks at indices above the last winner, the second wraps to 0..last.
    // -------------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_oh    = '0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_found && req[i] && (i > 32'(last_q))) begin
                win_found = 1'b1;
                win_oh[i] = 1'b1;
                win_idx   = IW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_found && req[i] && (i <= 32'(last_q))) begin
                win_found = 1'b1;
                win_oh[i] = 1'b1;
                win_idx   = IW'(i);
            end
        end

        win_sel  = 1'b0;
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_sel  = req_sel[i];
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Transaction FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        sel_d   = sel_q;
        data_d  = data_q;
        gnt_d   = '0;
        done_d  = 1'b0;
        commit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    win_d   = win_idx;
                    sel_d   = win_sel;
                    data_d  = win_data;
                    gnt_d   = win_oh;
                end
            end
            GRANT: begin
                state_d = COMMIT;
                done_d  = 1'b1;
                commit  = 1'b1;
            end
            COMMIT: begin
                state_d = IDLE;
                last_d  = win_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Slot store. Any clr at the same edge overrides the commit outcome.
    // -------------------------------------------------------------------------
    always_comb begin
        pa_d     = pa_q;
        pb_d     = pb_q;
        vld_d    = vld_q;
        dup_d    = dup_q;
        err_d    = err_q;
        slot_vld = sel_q ? vld_q[1] : vld_q[0];
        slot_val = sel_q ? pb_q : pa_q;

        if (commit) begin
            if (lock_hit) begin
                err_d = 1'b1;
            end else if (!slot_vld) begin
                if (sel_q) begin
                    pb_d     = data_q;
                    vld_d[1] = 1'b1;
                end else begin
                    pa_d     = data_q;
                    vld_d[0] = 1'b1;
                end
            end else if (slot_val == data_q) begin
                if (dup_q != 8'hFF) begin
                    dup_d = dup_q + 8'd1;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        if (clr) begin
            pa_d  = '0;
            pb_d  = '0;
            vld_d = '0;
            dup_d = '0;
            err_d = 1'b0;
        end
    end

`ifdef PARAM_CFG_ARB_LOCK_EN
    logic locked_q, locked_d;

    always_comb begin
        locked_d = locked_q | lock;
        if (clr) begin
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= locked_d;
        end
    end

    assign lock_hit = locked_q;
    assign locked   = locked_q;
`else
    assign lock_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            win_q   <= '0;
            sel_q   <= 1'b0;
            data_q  <= '0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            pa_q    <= '0;
            pb_q    <= '0;
            vld_q   <= '0;
            dup_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            vld_q   <= vld_d;
            dup_q   <= dup_d;
            err_q   <= err_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign param_a = pa_q;
    assign param_b = pb_q;
    assign valid   = vld_q;
    assign dup_cnt = dup_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: doc/param_cfg_arb.md
PARAM_CFG_ARB -- requirements
Module: param_cfg_arb

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requesters (2..8).
REQ-002 SHALL have parameter: DW, 8, parameter value width.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: req  input  NREQ  per-requester write request, held until own gnt bit seen.
REQ-006 SHALL have port: req_sel  input  NREQ  per-requester slot select, 0=param A, 1=param B.
REQ-007 SHALL have port: req_data  input  NREQ*DW  per-requester value, requester i at bits [i*DW +: DW].
REQ-008 SHALL have port: clr  input  1  synchronous clear of slot contents and flags.
REQ-009 SHALL have port: gnt  output  NREQ  one-hot grant, registered.
REQ-010 SHALL have port: done  output  1  one-cycle pulse, commit result valid.
REQ-011 SHALL have port: param_a, param_b  output  DW each  current slot values.
REQ-012 SHALL have port: valid  output  2  per-slot defined flags, bit0=A, bit1=B.
REQ-013 SHALL have port: dup_cnt  output  8  count of compatible redefinitions, saturating at 255.
REQ-014 SHALL have port: err  output  1  sticky incompatible-redefinition flag.
REQ-015 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, COMMIT: IDLE->GRANT when |req at the edge; GRANT->COMMIT always; COMMIT->IDLE always.
REQ-017 SHALL, on the IDLE->GRANT edge, pick the winner round-robin: search starts at index last_winner+1 mod NREQ; last_winner resets to NREQ-1, so the first search starts at 0.
REQ-018 SHALL latch the winner index, req_sel and req_data on the IDLE->GRANT edge; later input changes are ignored for that transaction.
REQ-019 SHALL assert gnt[winner] for exactly the GRANT cycle only; gnt is all-zero in every other state.
REQ-020 SHALL, on the GRANT->COMMIT edge: slot not valid -> store value, set valid bit; valid with equal value -> value unchanged, dup_cnt+1 (saturating); valid with different value -> value unchanged, err set.
REQ-021 SHALL pulse done for the COMMIT cycle; updated outputs are visible in that same cycle (latency req-sampled to done = 2 cycles; throughput one transaction per 3 cycles).
REQ-022 SHALL update last_winner on the COMMIT->IDLE edge.
REQ-023 SHALL ignore req in GRANT and COMMIT; a requester still asserting req in IDLE is re-arbitrated normally.
REQ-024 SHALL, when clr is high at an edge in any state, clear param_a, param_b, valid, dup_cnt and err at that edge; clr wins over a simultaneous GRANT->COMMIT update; FSM and last_winner are unaffected.

Reset
REQ-025 SHALL, while rst_n is low, immediately force state IDLE, gnt=0, done=0, busy=0, param_a=param_b=0, valid=0, dup_cnt=0, err=0, last_winner=NREQ-1, regardless of clk.
REQ-026 SHALL abandon any in-flight transaction on reset (no commit); operation resumes on the first edge after rst_n rises.

Configuration
REQ-027 SHALL provide macro PARAM_CFG_ARB_LOCK_EN: when defined, add input lock (1 bit) and output locked (1 bit, reset 0).
REQ-028 SHALL, with PARAM_CFG_ARB_LOCK_EN defined, set locked sticky when lock=1 at an edge; while locked, a commit is discarded (values, valid, dup_cnt unchanged) and err is set; clr also clears locked.
REQ-029 SHALL, without PARAM_CFG_ARB_LOCK_EN, omit the lock/locked ports; commits always follow REQ-020.

Verification
REQ-030 SHALL cover: req=0001, sel0=0, data0=0x12 -> gnt=0001 next cycle, then done, param_a=0x12, valid=01.
REQ-031 SHALL cover: after REQ-030, req=0010 sel=0 data=0x12 -> dup_cnt=1, err=0; then req=0100 sel=0 data=0x34 -> err=1, param_a stays 0x12.
REQ-032 SHALL cover: req=1111 held continuously from reset -> gnt order 0001,0010,0100,1000,0001 with 3-cycle spacing.
REQ-033 SHALL cover: clr=1 on the GRANT->COMMIT edge of a write to B -> valid=00, param_b=0, dup_cnt=0, err=0 in COMMIT, done still pulses.
REQ-034 SHALL cover: rst_n low mid-GRANT -> gnt=0 and busy=0 immediately without a clock; no slot update.
REQ-035 SHALL cover, with PARAM_CFG_ARB_LOCK_EN: lock pulse, then write B=0x55 -> valid[1]=0, err=1, locked=1; clr -> locked=0.
